// File: rtl/dual_issue_scoreboard_if.sv
// Fetch-to-decode bus of the dual-issue stage.
//   master : fetch/redirect side (drives flush, in_valid, in_instr0/1; sees in_ready and issue results)
//   slave  : the issue stage itself
//   flush, in_valid, in_ready, in_instr0, in_instr1 : enqueue side
//   out_valid0/1, out_instr0/1, issue_stall        : registered issue results
//   busy_map, q_count                               : scoreboard and queue occupancy status
interface dual_issue_scoreboard_if #(
   parameter int unsigned QDEPTH = 4
);
   localparam int unsigned QW = $clog2(QDEPTH + 1);

   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_instr0;
   logic [15:0]   in_instr1;
   logic          out_valid0;
   logic [15:0]   out_instr0;
   logic          out_valid1;
   logic [15:0]   out_instr1;
   logic          issue_stall;
   logic [7:0]    busy_map;
   logic [QW-1:0] q_count;

   modport master (
      output flush, in_valid, in_instr0, in_instr1,
      input  in_ready, out_valid0, out_instr0, out_valid1, out_instr1,
      input  issue_stall, busy_map, q_count
   );

   modport slave (
      input  flush, in_valid, in_instr0, in_instr1,
      output in_ready, out_valid0, out_instr0, out_valid1, out_instr1,
      output issue_stall, busy_map, q_count
   );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// In-order dual-issue stage: a small instruction queue fed by fetch pairs, plus a per-register
// countdown scoreboard. Issues 0..2 instructions per cycle in program order, stalling on RAW.
// Instruction: [15:12] opcode (0 = nop), [11] imm (rs1 only), [10:8] rd, [7:5] rs1, [4:2] rs2.
// Ports: clk, rst_n (async, active-low), bus (dual_issue_scoreboard_if.slave).
// Build option: define FORWARD_EN to treat a register as sourceable once its count is <= 1.
module dual_issue_scoreboard #(
   parameter int unsigned QDEPTH    = 4,
   parameter int unsigned HAZ_DEPTH = 2,
   parameter int unsigned NUM_REGS  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dual_issue_scoreboard_if.slave bus
);
   localparam int unsigned IW = 16;
   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned QW = $clog2(QDEPTH + 1);
   localparam int unsigned CW = 3;
   localparam int unsigned RW = 3;

   logic [IW-1:0]       mem_q [QDEPTH];
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [QW-1:0]       count_q, count_d;
   logic [CW-1:0]       cnt_q [NUM_REGS];
   logic [CW-1:0]       cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                out_valid0_q, out_valid1_q, issue_stall_q;
   logic [IW-1:0]       out_instr0_q, out_instr1_q;

   logic                in_ready_c, acc_c, wr0_c, wr1_c;
   logic [NUM_REGS-1:0] rdy_c;
   logic [IW-1:0]       h0_c, h1_c;
   logic                h0_vld_c, h1_vld_c, h0_ok_c, h1_ok_c, h1_dep_c;
   logic                iss0_c, iss1_c;
   logic [1:0]          enq_n_c, deq_n_c;

   // Room for a whole pair, judged on the registered count
   assign in_ready_c = (count_q <= QW'(QDEPTH - 2));

   // Enqueue: nops are squeezed out so the queue holds only real work
   always_comb begin
      acc_c   = bus.in_valid && in_ready_c && !bus.flush;
      wr0_c   = acc_c && (bus.in_instr0[15:12] != 4'd0);
      wr1_c   = acc_c && (bus.in_instr1[15:12] != 4'd0);
      enq_n_c = {1'b0, wr0_c} + {1'b0, wr1_c};
   end

   // Source readiness per register
   always_comb begin
      rdy_c = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
`ifdef FORWARD_EN
         rdy_c[r] = (cnt_q[r] <= CW'(1));
`else
         rdy_c[r] = (cnt_q[r] == '0);
`endif
      end
   end

   // Issue selection from the two oldest queue entries
   always_comb begin
      h0_c     = mem_q[rd_ptr_q];
      h1_c     = mem_q[rd_ptr_q + PW'(1)];
      h0_vld_c = (count_q != '0);
      h1_vld_c = (count_q >= QW'(2));
      h0_ok_c  = rdy_c[h0_c[7:5]] && (h0_c[11] || rdy_c[h0_c[4:2]]);
      h1_ok_c  = rdy_c[h1_c[7:5]] && (h1_c[11] || rdy_c[h1_c[4:2]]);
      // Slot 1 may not read or rewrite what slot 0 produces this cycle
      h1_dep_c = (h1_c[7:5] == h0_c[10:8]) ||
                 (!h1_c[11] && (h1_c[4:2] == h0_c[10:8])) ||
                 (h1_c[10:8] == h0_c[10:8]);
      iss0_c   = h0_vld_c && h0_ok_c && !bus.flush;
      iss1_c   = iss0_c && h1_vld_c && h1_ok_c && !h1_dep_c;
      deq_n_c  = {1'b0, iss0_c} + {1'b0, iss1_c};
   end

   // Queue pointer and occupancy update; flush empties the queue
   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(deq_n_c);
      wr_ptr_d = wr_ptr_q + PW'(enq_n_c);
      count_d  = count_q + QW'(enq_n_c) - QW'(deq_n_c);
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Scoreboard countdown; a fresh issue reloads and wins over the decrement
   always_comb begin
      busy_d = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CW'(1);
         if (iss0_c && (h0_c[10:8] == RW'(r))) cnt_d[r] = CW'(HAZ_DEPTH);
         if (iss1_c && (h1_c[10:8] == RW'(r))) cnt_d[r] = CW'(HAZ_DEPTH);
         busy_d[r] = (cnt_d[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         busy_q        <= '0;
         out_valid0_q  <= 1'b0;
         out_valid1_q  <= 1'b0;
         out_instr0_q  <= '0;
         out_instr1_q  <= '0;
         issue_stall_q <= 1'b0;
      end else begin
         if (wr0_c) mem_q[wr_ptr_q] <= bus.in_instr0;
         if (wr1_c) mem_q[wr_ptr_q + PW'(wr0_c)] <= bus.in_instr1;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         busy_q        <= busy_d;
         out_valid0_q  <= iss0_c;
         out_valid1_q  <= iss1_c;
         out_instr0_q  <= iss0_c ? h0_c : '0;
         out_instr1_q  <= iss1_c ? h1_c : '0;
         issue_stall_q <= h0_vld_c && !iss0_c && !bus.flush;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid0  = out_valid0_q;
   assign bus.out_instr0  = out_instr0_q;
   assign bus.out_valid1  = out_valid1_q;
   assign bus.out_instr1  = out_instr1_q;
   assign bus.issue_stall = issue_stall_q;
   assign bus.busy_map    = busy_q;
   assign bus.q_count     = count_q;
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed bench for dual_issue_scoreboard (QDEPTH=4, HAZ_DEPTH=2).
module tb_dual_issue_scoreboard;
   localparam int unsigned QDEPTH = 4;
   localparam logic [15:0] I_R1  = 16'h1100;  // rd1
   localparam logic [15:0] I_R2  = 16'h1220;  // rd2, rs1=1
   localparam logic [15:0] I_R3  = 16'h1300;  // rd3
   localparam logic [15:0] I_R4  = 16'h1400;  // rd4
   localparam logic [15:0] I_R5  = 16'h1500;  // rd5
   localparam logic [15:0] I_R6  = 16'h1600;  // rd6
   localparam logic [15:0] I_R7  = 16'h1700;  // rd7
   localparam logic [15:0] I_NOP = 16'h0000;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   logic [15:0] got[$];
   logic [15:0] exp_drain [4];

   always #5 clk = ~clk;

   dual_issue_scoreboard_if #(.QDEPTH(QDEPTH)) bus ();

   dual_issue_scoreboard #(
      .QDEPTH   (QDEPTH),
      .HAZ_DEPTH(2),
      .NUM_REGS (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
      bus.in_valid  = v;
      bus.in_instr0 = a;
      bus.in_instr1 = b;
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.flush = 1'b0;
      drive(1'b0, I_NOP, I_NOP);
      tick();
      tick();
      chk("rst_q_count", 16'(bus.q_count), 16'd0);
      chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
      chk("rst_out_valid0", 16'(bus.out_valid0), 16'd0);
      chk("rst_busy", 16'(bus.busy_map), 16'h00);
      rst_n = 1'b1;
      tick();

      // Independent pair issues together one edge after acceptance
      drive(1'b1, I_R1, I_R3);
      tick();
      chk("pair_q_count", 16'(bus.q_count), 16'd2);
      drive(1'b0, I_NOP, I_NOP);
      tick();
      chk("pair_v0", 16'(bus.out_valid0), 16'd1);
      chk("pair_i0", bus.out_instr0, I_R1);
      chk("pair_v1", 16'(bus.out_valid1), 16'd1);
      chk("pair_i1", bus.out_instr1, I_R3);
      chk("pair_busy1", 16'(bus.busy_map), 16'h0A);
      chk("pair_q_empty", 16'(bus.q_count), 16'd0);
      tick();
      chk("pair_busy2", 16'(bus.busy_map), 16'h0A);
      chk("pair_idle_v0", 16'(bus.out_valid0), 16'd0);
      chk("pair_idle_i0", bus.out_instr0, 16'h0000);
      tick();
      chk("pair_busy3", 16'(bus.busy_map), 16'h00);

      // RAW between slots, then head stall on the busy source
      drive(1'b1, I_R1, I_R2);
      tick();
      drive(1'b0, I_NOP, I_NOP);
      tick();
      chk("raw_i0", bus.out_instr0, I_R1);
      chk("raw_v1", 16'(bus.out_valid1), 16'd0);
      chk("raw_i1", bus.out_instr1, 16'h0000);
      chk("raw_q", 16'(bus.q_count), 16'd1);
      tick();
      chk("raw_stall_k2", 16'(bus.issue_stall), 16'd1);
      chk("raw_v0_k2", 16'(bus.out_valid0), 16'd0);
      chk("raw_busy_k2", 16'(bus.busy_map), 16'h02);
      tick();
`ifdef FORWARD_EN
      chk("raw_i0_k3", bus.out_instr0, I_R2);
      chk("raw_stall_k3", 16'(bus.issue_stall), 16'd0);
`else
      chk("raw_i0_k3", bus.out_instr0, 16'h0000);
      chk("raw_stall_k3", 16'(bus.issue_stall), 16'd1);
`endif
      tick();
`ifdef FORWARD_EN
      chk("raw_v0_k4", 16'(bus.out_valid0), 16'd0);
`else
      chk("raw_i0_k4", bus.out_instr0, I_R2);
`endif
      chk("raw_stall_k4", 16'(bus.issue_stall), 16'd0);
      chk("raw_busy_k4", 16'(bus.busy_map), 16'h04);
      tick();
      tick();
      tick();

      // Back-pressure while the head is stalled, then in-order drain
      drive(1'b1, I_R1, I_NOP);
      tick();
      chk("bp_nop_drop", 16'(bus.q_count), 16'd1);
      drive(1'b1, I_R2, I_R3);
      tick();
      chk("bp_prod_i0", bus.out_instr0, I_R1);
      chk("bp_prod_v1", 16'(bus.out_valid1), 16'd0);
      chk("bp_q2", 16'(bus.q_count), 16'd2);
      drive(1'b1, I_R5, I_R6);
      tick();
      chk("bp_q_full", 16'(bus.q_count), 16'd4);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
      chk("bp_stall", 16'(bus.issue_stall), 16'd1);
      drive(1'b1, I_R7, I_R4);
      tick();
      drive(1'b0, I_NOP, I_NOP);
      for (int c = 0; c < 6; c++) begin
         chk("bp_slot_order", 16'(bus.out_valid1 & ~bus.out_valid0), 16'd0);
         if (bus.out_valid0) got.push_back(bus.out_instr0);
         if (bus.out_valid1) got.push_back(bus.out_instr1);
         if (c < 5) tick();
      end
      exp_drain[0] = I_R2;
      exp_drain[1] = I_R3;
      exp_drain[2] = I_R5;
      exp_drain[3] = I_R6;
      chk("bp_drain_len", 16'(got.size()), 16'd4);
      for (int i = 0; i < 4; i++) begin
         chk("bp_drain_item", (i < got.size()) ? got[i] : 16'hDEAD, exp_drain[i]);
      end
      chk("bp_q_after", 16'(bus.q_count), 16'd0);
      tick();
      tick();
      tick();

      // Leading nop in a pair is dropped
      drive(1'b1, I_NOP, I_R3);
      tick();
      chk("nop_q", 16'(bus.q_count), 16'd1);
      drive(1'b0, I_NOP, I_NOP);
      tick();
      chk("nop_i0", bus.out_instr0, I_R3);
      chk("nop_v1", 16'(bus.out_valid1), 16'd0);
      tick();
      tick();

      // Flush drops queue and input but keeps the scoreboard counting
      drive(1'b1, I_R1, I_NOP);
      tick();
      drive(1'b1, I_R2, I_R3);
      tick();
      chk("fl_pre_q", 16'(bus.q_count), 16'd2);
      chk("fl_pre_busy", 16'(bus.busy_map), 16'h02);
      bus.flush = 1'b1;
      drive(1'b1, I_R5, I_R6);
      tick();
      chk("fl_q", 16'(bus.q_count), 16'd0);
      chk("fl_v0", 16'(bus.out_valid0), 16'd0);
      chk("fl_i0", bus.out_instr0, 16'h0000);
      chk("fl_v1", 16'(bus.out_valid1), 16'd0);
      chk("fl_busy", 16'(bus.busy_map), 16'h02);
      chk("fl_stall", 16'(bus.issue_stall), 16'd0);
      bus.flush = 1'b0;
      drive(1'b0, I_NOP, I_NOP);
      tick();
      chk("fl_post_v0", 16'(bus.out_valid0), 16'd0);
      chk("fl_post_q", 16'(bus.q_count), 16'd0);
      chk("fl_post_busy", 16'(bus.busy_map), 16'h00);
      tick();

      // Asynchronous reset with a partly full queue
      drive(1'b1, I_R1, I_NOP);
      tick();
      drive(1'b1, I_R2, I_R3);
      tick();
      drive(1'b1, I_R5, I_NOP);
      tick();
      drive(1'b0, I_NOP, I_NOP);
      chk("ar_pre_q", 16'(bus.q_count), 16'd3);
      chk("ar_pre_stall", 16'(bus.issue_stall), 16'd1);
      chk("ar_pre_busy", 16'(bus.busy_map), 16'h02);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_q", 16'(bus.q_count), 16'd0);
      chk("ar_busy", 16'(bus.busy_map), 16'h00);
      chk("ar_in_ready", 16'(bus.in_ready), 16'd1);
      chk("ar_stall", 16'(bus.issue_stall), 16'd0);
      chk("ar_v0", 16'(bus.out_valid0), 16'd0);
      chk("ar_i1", bus.out_instr1, 16'h0000);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("ar_quiet_v0", 16'(bus.out_valid0), 16'd0);
      chk("ar_quiet_q", 16'(bus.q_count), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
